// File: rtl/touch_bar_mapper_pkg.sv
// Shared definitions for the touch-bar mapper and its sequential divider.
//   - tbm_state_e : controller state encoding
//   - PCT_FULL    : full-scale percentage value
//   - clog2_min1  : ceiling log2, never less than 1 (keeps index ports at least 1 bit wide)
package touch_bar_mapper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_DIVIDE   = 2'd2,
        ST_UPDATE   = 2'd3
    } tbm_state_e;

    localparam int unsigned PCT_FULL = 32'd100;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = 32'(i + 1);
            end else begin
                r = r;
            end
        end
        if (r == 32'd0) begin
            r = 32'd1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/touch_bar_mapper_seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock.
// A start pulse loads the operands; exactly NUM_W step cycles follow and
// done_o pulses for one cycle after the last step with quo_o stable.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   start_i : load num_i/den_i and begin (ignored bits of a running division are discarded)
//   num_i   : numerator, NUM_W bits
//   den_i   : denominator, DEN_W bits, must be non-zero
//   quo_o   : floor(num/den), valid while done_o is high and held afterwards
//   done_o  : one-cycle completion pulse
module touch_bar_mapper_seq_divider
    import touch_bar_mapper_pkg::*;
#(
    parameter int NUM_W = 19,
    parameter int DEN_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [NUM_W-1:0] quo_o,
    output logic             done_o
);

    localparam int CNT_W = int'(clog2_min1(32'(NUM_W + 1)));

    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [DEN_W:0]   shifted_s;
    logic [DEN_W:0]   trial_s;

    // Partial remainder shifted left with the next numerator bit, and the trial subtraction.
    always_comb begin
        shifted_s = {rem_q, quo_q[NUM_W-1]};
        trial_s   = shifted_s - {1'b0, den_q};
    end

    // Next-state logic: load on start, otherwise one restoring step per cycle while running.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            quo_d = num_i;
            rem_d = '0;
            den_d = den_i;
            cnt_d = CNT_W'(NUM_W);
            run_d = 1'b1;
        end else if (run_q) begin
            // The remainder is always below den_q, so the shifted value fits in DEN_W+1 bits
            // and the kept remainder fits back in DEN_W bits.
            if (shifted_s >= {1'b0, den_q}) begin
                rem_d = trial_s[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = shifted_s[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Divider state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quo_o  = quo_q;
    assign done_o = done_q;

endmodule

// File: rtl/touch_bar_mapper.sv
// Maps touch-panel coordinates onto NUM_BARS vertical slider bars and keeps one
// 0..100 % value per bar for the PWM generators.
// A touch is accepted only after CONFIRM consecutive touches land on the same bar;
// the percentage is then computed exactly by a sequential divider and written either
// directly or slew-limited by MAX_STEP.
// Ports:
//   ADC_DCLK        : clock, rising edge
//   RST_N           : synchronous active-low reset
//   fin_transmision : coordinate pair complete (level, may last several cycles)
//   X_COORD/Y_COORD : touch coordinates
//   SLEW_MODE       : 0 absolute, 1 slew-limited; sampled with the coordinates
//   VALUES          : channel i at [i*VAL_W +: VAL_W]
//   VALID           : one-cycle pulse after a channel was written
//   ACTIVE_BAR      : index of the bar last written
//   BUSY            : high from capture until the write completes
module touch_bar_mapper
    import touch_bar_mapper_pkg::*;
#(
    parameter int COORD_W  = 12,
    parameter int NUM_BARS = 2,
    parameter int VAL_W    = 7,
    parameter logic [NUM_BARS*COORD_W-1:0] BAR_X_LO = {12'd614, 12'd2048},
    parameter logic [NUM_BARS*COORD_W-1:0] BAR_X_HI = {12'd1024, 12'd2457},
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 4095,
    parameter int CONFIRM  = 2,
    parameter int INIT_VAL = 50,
    parameter int MAX_STEP = 10
) (
    input  logic                                 ADC_DCLK,
    input  logic                                 RST_N,
    input  logic                                 fin_transmision,
    input  logic [COORD_W-1:0]                   X_COORD,
    input  logic [COORD_W-1:0]                   Y_COORD,
    input  logic                                 SLEW_MODE,
    output logic [NUM_BARS*VAL_W-1:0]            VALUES,
    output logic                                 VALID,
    output logic [clog2_min1(NUM_BARS)-1:0]      ACTIVE_BAR,
    output logic                                 BUSY
);

    localparam int IDX_W  = int'(clog2_min1(32'(NUM_BARS)));
    localparam int NUM_W  = COORD_W + 7;
    localparam int CONF_W = int'(clog2_min1(32'(CONFIRM + 1)));
    localparam logic [COORD_W-1:0] Y_MIN_C = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_MAX_C = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] Y_SPAN_C = COORD_W'(Y_MAX - Y_MIN);
    localparam logic [VAL_W-1:0]   STEP_C = VAL_W'(MAX_STEP);
    localparam logic [VAL_W-1:0]   INIT_C = VAL_W'(INIT_VAL);

    tbm_state_e         state_q, state_d;
    logic               fin_q;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               slew_q, slew_d;
    logic [CONF_W-1:0]  cnt_q, cnt_d;
    logic               last_vld_q, last_vld_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [VAL_W-1:0]   vals_q [NUM_BARS];
    logic [VAL_W-1:0]   vals_d [NUM_BARS];
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   active_q, active_d;
    logic               busy_q, busy_d;

    logic               event_s;
    logic               hit_s;
    logic [IDX_W-1:0]   hit_idx_s;
    logic [CONF_W-1:0]  cnt_new_s;
    logic [COORD_W:0]   below_diff_s;
    logic [COORD_W:0]   above_diff_s;
    logic [COORD_W-1:0] y_clamp_s;
    logic [NUM_W-1:0]   num_s;
    logic               div_start_s;
    logic [NUM_W-1:0]   div_quo_s;
    logic               div_done_s;
    logic [VAL_W-1:0]   quo_val_s;
    logic [VAL_W-1:0]   cur_val_s;
    logic [VAL_W-1:0]   diff_s;
    logic [VAL_W-1:0]   new_val_s;

    // Rising edge of the transfer-complete level: high now, low at the previous edge.
    assign event_s = fin_transmision & ~fin_q;

    // Bar lookup on the latched X; scanning downward leaves the lowest matching index.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NUM_BARS - 1; i >= 0; i--) begin
            if ((x_q >= BAR_X_LO[i*COORD_W +: COORD_W]) &&
                (x_q <= BAR_X_HI[i*COORD_W +: COORD_W])) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Clamp Y into the calibrated range and scale to a percentage numerator.
    // The borrow bit of each widened subtraction tells whether Y is out of range.
    always_comb begin
        below_diff_s = {1'b0, y_q} - {1'b0, Y_MIN_C};
        above_diff_s = {1'b0, Y_MAX_C} - {1'b0, y_q};
        if (below_diff_s[COORD_W]) begin
            y_clamp_s = Y_MIN_C;
        end else if (above_diff_s[COORD_W]) begin
            y_clamp_s = Y_MAX_C;
        end else begin
            y_clamp_s = y_q;
        end
        num_s = NUM_W'(y_clamp_s - Y_MIN_C) * NUM_W'(PCT_FULL);
    end

    touch_bar_mapper_seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (COORD_W)
    ) u_div (
        .clk_i   (ADC_DCLK),
        .rst_ni  (RST_N),
        .start_i (div_start_s),
        .num_i   (num_s),
        .den_i   (Y_SPAN_C),
        .quo_o   (div_quo_s),
        .done_o  (div_done_s)
    );

    // New channel value: absolute quotient, or a step of at most MAX_STEP toward it.
    always_comb begin
        if (div_quo_s > NUM_W'(PCT_FULL)) begin
            quo_val_s = VAL_W'(PCT_FULL);
        end else begin
            quo_val_s = div_quo_s[VAL_W-1:0];
        end
        cur_val_s = vals_q[cur_idx_q];
        diff_s    = '0;
        new_val_s = quo_val_s;
        if (!slew_q) begin
            new_val_s = quo_val_s;
        end else if (quo_val_s > cur_val_s) begin
            diff_s    = quo_val_s - cur_val_s;
            new_val_s = (diff_s > STEP_C) ? (cur_val_s + STEP_C) : quo_val_s;
        end else begin
            diff_s    = cur_val_s - quo_val_s;
            new_val_s = (diff_s > STEP_C) ? (cur_val_s - STEP_C) : quo_val_s;
        end
    end

    // Controller next-state and output logic.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        slew_d      = slew_q;
        cnt_d       = cnt_q;
        last_vld_d  = last_vld_q;
        last_idx_d  = last_idx_q;
        cur_idx_d   = cur_idx_q;
        vals_d      = vals_q;
        valid_d     = 1'b0;
        active_d    = active_q;
        div_start_s = 1'b0;
        cnt_new_s   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (event_s) begin
                    x_d     = X_COORD;
                    y_d     = Y_COORD;
                    slew_d  = SLEW_MODE;
                    state_d = ST_CLASSIFY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLASSIFY: begin
                if (!hit_s) begin
                    // A touch outside every bar breaks the confirmation run.
                    cnt_d      = '0;
                    last_vld_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    if (last_vld_q && (last_idx_q == hit_idx_s)) begin
                        cnt_new_s = (cnt_q >= CONF_W'(CONFIRM)) ? cnt_q : (cnt_q + CONF_W'(1));
                    end else begin
                        cnt_new_s = CONF_W'(1);
                    end
                    cnt_d      = cnt_new_s;
                    last_vld_d = 1'b1;
                    last_idx_d = hit_idx_s;
                    cur_idx_d  = hit_idx_s;
                    if (cnt_new_s >= CONF_W'(CONFIRM)) begin
                        div_start_s = 1'b1;
                        state_d     = ST_DIVIDE;
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done_s) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_UPDATE: begin
                vals_d[cur_idx_q] = new_val_s;
                active_d          = cur_idx_q;
                valid_d           = 1'b1;
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // All controller and output registers; reset overrides everything, including a running division.
    always_ff @(posedge ADC_DCLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            fin_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            slew_q     <= 1'b0;
            cnt_q      <= '0;
            last_vld_q <= 1'b0;
            last_idx_q <= '0;
            cur_idx_q  <= '0;
            for (int i = 0; i < NUM_BARS; i++) begin
                vals_q[i] <= INIT_C;
            end
            valid_q    <= 1'b0;
            active_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fin_q      <= fin_transmision;
            x_q        <= x_d;
            y_q        <= y_d;
            slew_q     <= slew_d;
            cnt_q      <= cnt_d;
            last_vld_q <= last_vld_d;
            last_idx_q <= last_idx_d;
            cur_idx_q  <= cur_idx_d;
            vals_q     <= vals_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            busy_q     <= busy_d;
        end
    end

    // Pack the channel registers onto the output bus.
    always_comb begin
        VALUES = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            VALUES[i*VAL_W +: VAL_W] = vals_q[i];
        end
    end

    assign VALID      = valid_q;
    assign ACTIVE_BAR = active_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_touch_bar_mapper.sv
// Bench for touch_bar_mapper: dut_a uses default parameters, dut_b a narrowed Y range
// (100..3000) with single-touch confirmation; both see identical stimulus.
module tb_touch_bar_mapper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fin = 1'b0;
    logic        slew = 1'b0;
    logic [11:0] x = 12'd0;
    logic [11:0] y = 12'd0;
    logic [13:0] vals_a, vals_b;
    logic        valid_a, valid_b, busy_a, busy_b;
    logic [0:0]  act_a, act_b;

    int total = 0;
    int bad = 0;

    // Reference state: per dut, per bar value, confirmation run, last written bar.
    int m_val  [2][2];
    int m_last [2];
    int m_cnt  [2];
    int m_act  [2];
    int p_ymin [2] = '{0, 100};
    int p_ymax [2] = '{4095, 3000};
    int p_conf [2] = '{2, 1};
    int bar_lo [2] = '{2048, 614};
    int bar_hi [2] = '{2457, 1024};

    always #5 clk = ~clk;

    touch_bar_mapper dut_a (
        .ADC_DCLK(clk), .RST_N(rst_n), .fin_transmision(fin), .X_COORD(x), .Y_COORD(y),
        .SLEW_MODE(slew), .VALUES(vals_a), .VALID(valid_a), .ACTIVE_BAR(act_a), .BUSY(busy_a)
    );

    touch_bar_mapper #(.Y_MIN(100), .Y_MAX(3000), .CONFIRM(1)) dut_b (
        .ADC_DCLK(clk), .RST_N(rst_n), .fin_transmision(fin), .X_COORD(x), .Y_COORD(y),
        .SLEW_MODE(slew), .VALUES(vals_b), .VALID(valid_b), .ACTIVE_BAR(act_b), .BUSY(busy_b)
    );

    function automatic int find_bar(input int xv);
        for (int i = 0; i < 2; i++) begin
            if (xv >= bar_lo[i] && xv <= bar_hi[i]) return i;
        end
        return -1;
    endfunction

    function automatic int pct(input int d, input int yv);
        int yc;
        yc = yv;
        if (yc < p_ymin[d]) yc = p_ymin[d];
        if (yc > p_ymax[d]) yc = p_ymax[d];
        return (yc - p_ymin[d]) * 100 / (p_ymax[d] - p_ymin[d]);
    endfunction

    function automatic logic [13:0] exp_vals(input int d);
        return {7'(m_val[d][1]), 7'(m_val[d][0])};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_val[d][0] = 50; m_val[d][1] = 50;
            m_last[d] = -1; m_cnt[d] = 0; m_act[d] = 0;
        end
    endtask

    task automatic model_touch(input int d, input int xv, input int yv, input bit sl, output int upd);
        int b, q, cur;
        b = find_bar(xv);
        upd = 0;
        if (b < 0) begin
            m_cnt[d] = 0; m_last[d] = -1;
        end else begin
            if (b == m_last[d]) m_cnt[d] = (m_cnt[d] >= p_conf[d]) ? p_conf[d] : m_cnt[d] + 1;
            else begin m_cnt[d] = 1; m_last[d] = b; end
            if (m_cnt[d] >= p_conf[d]) begin
                q = pct(d, yv);
                cur = m_val[d][b];
                if (!sl) cur = q;
                else if (q > cur) cur = (q - cur > 10) ? cur + 10 : q;
                else cur = (cur - q > 10) ? cur - 10 : q;
                m_val[d][b] = cur;
                m_act[d] = b;
                upd = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; fin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    // One touch: drive fin high for 'hold' edges, watch both duts, compare with the model.
    task automatic touch(input int xv, input int yv, input bit sl, input int hold, input string tag);
        int upd [2];
        int vcount [2];
        int vfirst [2];
        bit busy0 [2];
        int clash [2];
        logic [13:0] ov;
        int oa;
        model_touch(0, xv, yv, sl, upd[0]);
        model_touch(1, xv, yv, sl, upd[1]);
        vcount = '{0, 0}; vfirst = '{-1, -1}; clash = '{0, 0}; busy0 = '{1'b0, 1'b0};
        @(negedge clk); x = 12'(xv); y = 12'(yv); slew = sl; fin = 1'b1;
        for (int c = 0; c < hold + 32; c++) begin
            @(posedge clk); #1;
            if (c == hold - 1) fin = 1'b0;
            if (c == 0) begin busy0[0] = busy_a; busy0[1] = busy_b; end
            if (valid_a) begin vcount[0]++; if (vfirst[0] < 0) vfirst[0] = c; if (busy_a) clash[0]++; end
            if (valid_b) begin vcount[1]++; if (vfirst[1] < 0) vfirst[1] = c; if (busy_b) clash[1]++; end
        end
        for (int d = 0; d < 2; d++) begin
            ov = (d == 0) ? vals_a : vals_b;
            oa = (d == 0) ? int'(act_a) : int'(act_b);
            total++;
            if (vcount[d] !== upd[d]) begin
                bad++; $display("FAIL %s dut%0d valid_pulses got %0d want %0d", tag, d, vcount[d], upd[d]);
            end
            if (upd[d] == 1) begin
                total++;
                if (vfirst[d] !== 22) begin
                    bad++; $display("FAIL %s dut%0d latency got %0d want 22", tag, d, vfirst[d]);
                end
            end
            total++;
            if (busy0[d] !== 1'b1) begin
                bad++; $display("FAIL %s dut%0d busy_after_capture got %0b want 1", tag, d, busy0[d]);
            end
            total++;
            if (clash[d] !== 0) begin
                bad++; $display("FAIL %s dut%0d busy_with_valid got %0d want 0", tag, d, clash[d]);
            end
            total++;
            if (ov !== exp_vals(d)) begin
                bad++; $display("FAIL %s dut%0d values got %h want %h", tag, d, ov, exp_vals(d));
            end
            total++;
            if (oa !== m_act[d]) begin
                bad++; $display("FAIL %s dut%0d active_bar got %0d want %0d", tag, d, oa, m_act[d]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (vals_a !== {7'd50, 7'd50} || vals_b !== {7'd50, 7'd50}) begin
            bad++; $display("FAIL reset values got %h/%h want %h", vals_a, vals_b, {7'd50, 7'd50});
        end
        total++;
        if ({valid_a, busy_a, act_a, valid_b, busy_b, act_b} !== 6'b0) begin
            bad++; $display("FAIL reset flags got %b want 000000", {valid_a, busy_a, act_a, valid_b, busy_b, act_b});
        end
    endtask

    task automatic test_confirm();
        touch(2252, 1351, 1'b0, 1, "confirm_first");
        touch(2252, 1351, 1'b0, 1, "confirm_second");
        total++;
        if (vals_a[6:0] !== 7'd32 || act_a !== 1'b0) begin
            bad++; $display("FAIL confirm_ch0 got %0d bar %0d want 32 bar 0", vals_a[6:0], act_a);
        end
    endtask

    task automatic test_bar1();
        touch(818, 2047, 1'b0, 1, "bar1_first");
        touch(818, 2047, 1'b0, 2, "bar1_second");
        total++;
        if (vals_a !== {7'd49, 7'd32}) begin
            bad++; $display("FAIL bar1_values got %h want %h", vals_a, {7'd49, 7'd32});
        end
    endtask

    task automatic test_no_bar_clears();
        touch(2252, 2000, 1'b0, 1, "clear_a");
        touch(1500, 2000, 1'b0, 1, "clear_nobar");
        touch(2252, 3000, 1'b0, 1, "clear_b");
        total++;
        if (vals_a[6:0] !== 7'd32) begin
            bad++; $display("FAIL clear_ch0_held got %0d want 32", vals_a[6:0]);
        end
    endtask

    task automatic test_extremes();
        touch(2048, 4095, 1'b0, 1, "ymax_a");
        touch(2457, 4095, 1'b0, 1, "ymax_b");
        total++;
        if (vals_a[6:0] !== 7'd100 || vals_b[6:0] !== 7'd100) begin
            bad++; $display("FAIL ymax got %0d/%0d want 100/100", vals_a[6:0], vals_b[6:0]);
        end
        touch(2300, 0, 1'b0, 1, "ymin");
        total++;
        if (vals_a[6:0] !== 7'd0 || vals_b[6:0] !== 7'd0) begin
            bad++; $display("FAIL ymin got %0d/%0d want 0/0", vals_a[6:0], vals_b[6:0]);
        end
        touch(614, 3500, 1'b0, 1, "clamp_a");
        touch(1024, 3500, 1'b0, 1, "clamp_b");
    endtask

    task automatic test_slew();
        int want [5] = '{60, 70, 80, 90, 90};
        do_reset();
        touch(2252, 3686, 1'b1, 1, "slew_0");
        for (int k = 0; k < 5; k++) begin
            touch(2252, 3686, 1'b1, 1, "slew_n");
            total++;
            if (vals_a[6:0] !== 7'(want[k])) begin
                bad++; $display("FAIL slew_step%0d got %0d want %0d", k, vals_a[6:0], want[k]);
            end
        end
    endtask

    task automatic test_hold_level();
        touch(818, 1000, 1'b0, 30, "hold_1");
        touch(818, 1000, 1'b0, 30, "hold_2");
    endtask

    task automatic test_random();
        int edges [8] = '{2048, 2457, 614, 1024, 613, 1025, 2047, 2458};
        int xv, r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: xv = $urandom_range(2048, 2457);
                1: xv = $urandom_range(614, 1024);
                2: xv = $urandom_range(1100, 2000);
                default: xv = edges[$urandom_range(0, 7)];
            endcase
            touch(xv, $urandom_range(0, 4095), 1'($urandom_range(0, 1)), $urandom_range(1, 4), "random");
        end
    endtask

    task automatic test_reset_mid_divide();
        int vc;
        touch(2252, 1000, 1'b0, 1, "pre_abort_1");
        touch(2252, 1000, 1'b0, 1, "pre_abort_2");
        @(negedge clk); x = 12'd2252; y = 12'd3000; slew = 1'b0; fin = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (c == 0) fin = 1'b0;
            if (c == 10) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        total++;
        if (vals_a !== {7'd50, 7'd50} || vals_b !== {7'd50, 7'd50} ||
            {valid_a, busy_a, act_a, valid_b, busy_b, act_b} !== 6'b0) begin
            bad++; $display("FAIL abort_reset got %h/%h flags %b want %h flags 000000", vals_a, vals_b,
                            {valid_a, busy_a, act_a, valid_b, busy_b, act_b}, {7'd50, 7'd50});
        end
        rst_n = 1'b1;
        model_reset();
        vc = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (valid_a || valid_b) vc++;
        end
        total++;
        if (vc !== 0) begin
            bad++; $display("FAIL abort_no_valid got %0d want 0", vc);
        end
        touch(2252, 1351, 1'b0, 1, "post_abort");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_confirm();
        test_bar1();
        test_no_bar_clears();
        test_extremes();
        test_slew();
        test_hold_level();
        test_random();
        test_reset_mid_divide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
